// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   uart_state_t    - transmitter FSM state encoding
//   UART_FRAME_BITS - bits per frame (10 for 8N1, 11 with parity)
//   UART_IDLE_LEVEL - line level while idle and during stop bits
//   uart_clamp_len  - limits a requested byte count to what the word holds
// Configuration macro: UART_TX_PARITY_EN adds the PARITY state and an 11-bit frame.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;
`else
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;
`endif

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // len is "bytes minus one"; anything beyond the word is clamped to the last byte.
    function automatic int unsigned uart_clamp_len(input int unsigned len,
                                                   input int unsigned nbytes);
        return (len > nbytes - 1) ? nbytes - 1 : len;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, CLK_DIV clk cycles per serial bit.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   restart  - holds the counter at 0 (bit period starts on release)
//   bit_tick - high on the last clk cycle of each bit period
module uart_baud_gen #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_multibyte.sv
// uart_tx_multibyte: sends 1..NBYTES bytes of a DATA_W-bit word as back-to-back
// 8N1 frames, byte 0 (LSBs) first, LSB of each byte first.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset (aborts any transfer, line high)
//   wr_en      - write strobe, accepted only while ready=1
//   wr_data    - word to send, captured at acceptance
//   len        - bytes to send minus one (clamped to NBYTES-1)
//   parity_odd - (UART_TX_PARITY_EN only) odd parity select, captured at acceptance
//   serial_out - UART line, idle high
//   ready/busy - registered handshake, busy = ~ready
//   done       - one-cycle pulse after the final stop bit
//   wr_err     - one-cycle pulse for a write dropped while busy
// Configuration macro: UART_TX_PARITY_EN inserts a parity bit after the data bits.
module uart_tx_multibyte
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned LEN_W   = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  len,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_odd,
`endif
    output logic              serial_out,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    localparam int unsigned NBYTES = DATA_W / 8;

    uart_state_t       state;
    logic [DATA_W-1:0] hold;
    logic [LEN_W-1:0]  bytes_left;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nxt;
    logic [7:0]        cur_byte;
    logic              bit_tick;
    logic              restart;
`ifdef UART_TX_PARITY_EN
    logic              parity_odd_q;
`endif

    // Counter is held at zero while idle so the start bit gets a full period
    // from the accepting edge; in other states it wraps on every bit boundary.
    assign restart  = (state == ST_IDLE);
    assign cur_byte = hold[7:0];
    assign bit_nxt  = bit_idx + 3'd1;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .bit_tick (bit_tick)
    );

    // serial_out is registered and loaded with the level of the bit being
    // entered, so it changes on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            hold       <= '0;
            bytes_left <= '0;
            bit_idx    <= '0;
            serial_out <= UART_IDLE_LEVEL;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_odd_q <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            wr_err <= 1'b0;

            if (state != ST_IDLE && wr_en) begin
                wr_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        hold       <= wr_data;
                        bytes_left <= LEN_W'(uart_clamp_len(32'(len), NBYTES));
`ifdef UART_TX_PARITY_EN
                        parity_odd_q <= parity_odd;
`endif
                        state      <= ST_START;
                        serial_out <= 1'b0;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_tick) begin
                        state      <= ST_DATA;
                        bit_idx    <= '0;
                        serial_out <= cur_byte[0];
                    end
                end

                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state      <= ST_PARITY;
                            serial_out <= (^cur_byte) ^ parity_odd_q;
`else
                            state      <= ST_STOP;
                            serial_out <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx    <= bit_nxt;
                            serial_out <= cur_byte[bit_nxt];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        state      <= ST_STOP;
                        serial_out <= UART_IDLE_LEVEL;
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_tick) begin
                        if (bytes_left != '0) begin
                            // Next frame starts immediately: no idle gap.
                            bytes_left <= bytes_left - 1'b1;
                            hold       <= hold >> 8;
                            state      <= ST_START;
                            serial_out <= 1'b0;
                        end else begin
                            state      <= ST_IDLE;
                            serial_out <= UART_IDLE_LEVEL;
                            ready      <= 1'b1;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    serial_out <= UART_IDLE_LEVEL;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
